// File: rtl/sbox_lookup_arbiter_if.sv
// Requester handshakes plus the dual-port S-box RAM port bundle for sbox_lookup_arbiter.
// slave = arbiter side; master = requesters and RAM side.
interface sbox_lookup_arbiter_if;
  logic         key_req;
  logic [31:0]  key_word;
  logic         key_ack;
  logic [31:0]  key_result;
  logic         st_req;
  logic         st_inv;
  logic [127:0] st_data;
  logic         st_ack;
  logic [127:0] st_result;
  logic         busy;
  logic         sbox_cea;
  logic [8:0]   sbox_ada;
  logic         sbox_ceb;
  logic [8:0]   sbox_adb;
  logic [7:0]   sbox_douta;
  logic [7:0]   sbox_doutb;

  modport slave (
    input  key_req, key_word, st_req, st_inv, st_data, sbox_douta, sbox_doutb,
    output key_ack, key_result, st_ack, st_result, busy,
           sbox_cea, sbox_ada, sbox_ceb, sbox_adb
  );

  modport master (
    output key_req, key_word, st_req, st_inv, st_data, sbox_douta, sbox_doutb,
    input  key_ack, key_result, st_ack, st_result, busy,
           sbox_cea, sbox_ada, sbox_ceb, sbox_adb
  );
endinterface

// File: rtl/sbox_lookup_arbiter.sv
// Round-robin sharing of one dual-port S-box RAM between SubWord (4 bytes) and SubBytes (16 bytes).
// Optional counters: define SBOX_LOOKUP_ARBITER_STATS_EN.
module sbox_lookup_arbiter #(
  parameter int READ_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  sbox_lookup_arbiter_if.slave bus
`ifdef SBOX_LOOKUP_ARBITER_STATS_EN
  ,
  output logic [15:0]          stat_key_ops,
  output logic [15:0]          stat_st_ops,
  output logic [15:0]          stat_conflicts
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  typedef enum logic {GRANT_KEY, GRANT_STATE} grant_t;

  state_t       state, state_next;
  grant_t       last_grant, cur_grant;
  logic         grant_key_now, grant_st_now;
  logic [127:0] operand;
  logic         inv;
  logic [2:0]   k;
  logic [2:0]   last_k;
  logic [127:0] collect, collect_next;
  logic [31:0]  key_result_q;
  logic [127:0] st_result_q;
  logic [READ_LAT-1:0] tag_valid;
  logic [2:0]   tag_idx [READ_LAT];
  logic         tag_out_valid;
  logic [2:0]   tag_out_idx;

  assign last_k        = (cur_grant == GRANT_KEY) ? 3'd1 : 3'd7;
  assign tag_out_valid = tag_valid[READ_LAT-1];
  assign tag_out_idx   = tag_idx[READ_LAT-1];

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant_key_now = 1'b0;
    grant_st_now  = 1'b0;
    if (bus.key_req && bus.st_req) begin
      grant_key_now = (last_grant == GRANT_STATE);
      grant_st_now  = (last_grant == GRANT_KEY);
    end else begin
      grant_key_now = bus.key_req;
      grant_st_now  = bus.st_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    bus.sbox_cea = 1'b0;
    bus.sbox_ceb = 1'b0;
    bus.sbox_ada = 9'd0;
    bus.sbox_adb = 9'd0;
    case (state)
      IDLE:  if (grant_key_now || grant_st_now) state_next = ISSUE;
      ISSUE: begin
        bus.sbox_cea = 1'b1;
        bus.sbox_ceb = 1'b1;
        bus.sbox_ada = {inv, operand[{k, 4'b0000} +: 8]};
        bus.sbox_adb = {inv, operand[{k, 4'b1000} +: 8]};
        if (k == last_k) state_next = DRAIN;
      end
      DRAIN: if (tag_out_valid && (tag_out_idx == last_k)) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    collect_next = collect;
    if (tag_out_valid) begin
      collect_next[{tag_out_idx, 4'b0000} +: 8] = bus.sbox_douta;
      collect_next[{tag_out_idx, 4'b1000} +: 8] = bus.sbox_doutb;
    end
  end

  // Results are published only on the final capture so they stay stable between acks.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant   <= GRANT_STATE;
      cur_grant    <= GRANT_STATE;
      operand      <= '0;
      inv          <= 1'b0;
      k            <= 3'd0;
      collect      <= '0;
      key_result_q <= '0;
      st_result_q  <= '0;
    end else begin
      collect <= collect_next;
      if (state == IDLE && (grant_key_now || grant_st_now)) begin
        cur_grant  <= grant_key_now ? GRANT_KEY : GRANT_STATE;
        last_grant <= grant_key_now ? GRANT_KEY : GRANT_STATE;
        operand    <= grant_key_now ? {96'd0, bus.key_word} : bus.st_data;
        inv        <= grant_key_now ? 1'b0 : bus.st_inv;
        k          <= 3'd0;
      end else if (state == ISSUE) begin
        k <= k + 3'd1;
      end
      if (state == DRAIN && state_next == DONE) begin
        if (cur_grant == GRANT_KEY) key_result_q <= collect_next[31:0];
        else                        st_result_q  <= collect_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid <= '0;
      for (int i = 0; i < READ_LAT; i++) tag_idx[i] <= 3'd0;
    end else begin
      tag_valid[0] <= (state == ISSUE);
      tag_idx[0]   <= k;
      for (int i = 1; i < READ_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_idx[i]   <= tag_idx[i-1];
      end
    end
  end

  assign bus.key_ack    = (state == DONE) && (cur_grant == GRANT_KEY);
  assign bus.st_ack     = (state == DONE) && (cur_grant == GRANT_STATE);
  assign bus.busy       = (state != IDLE);
  assign bus.key_result = key_result_q;
  assign bus.st_result  = st_result_q;

`ifdef SBOX_LOOKUP_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_key_ops   <= 16'd0;
      stat_st_ops    <= 16'd0;
      stat_conflicts <= 16'd0;
    end else begin
      if (bus.key_ack && stat_key_ops != 16'hFFFF) stat_key_ops <= stat_key_ops + 16'd1;
      if (bus.st_ack && stat_st_ops != 16'hFFFF)   stat_st_ops  <= stat_st_ops + 16'd1;
      if (state == IDLE && bus.key_req && bus.st_req && stat_conflicts != 16'hFFFF)
        stat_conflicts <= stat_conflicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sbox_lookup_arbiter.sv
// Directed bench: dut1 uses READ_LAT=1, dut2 READ_LAT=2, each with its own behavioural S-box RAM.
module tb_sbox_lookup_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sbox_lookup_arbiter_if bus1();
  sbox_lookup_arbiter_if bus2();

`ifdef SBOX_LOOKUP_ARBITER_STATS_EN
  logic [15:0] s1_key, s1_st, s1_conf, s2_key, s2_st, s2_conf;
`endif

  sbox_lookup_arbiter #(.READ_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
`ifdef SBOX_LOOKUP_ARBITER_STATS_EN
    , .stat_key_ops(s1_key), .stat_st_ops(s1_st), .stat_conflicts(s1_conf)
`endif
  );

  sbox_lookup_arbiter #(.READ_LAT(2)) u_dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
`ifdef SBOX_LOOKUP_ARBITER_STATS_EN
    , .stat_key_ops(s2_key), .stat_st_ops(s2_st), .stat_conflicts(s2_conf)
`endif
  );

  logic [7:0] sbox_mem [512];
  logic [7:0] stage_a, stage_b;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'd0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] r;
    r = 8'd1;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    if (x == 8'd0) r = 8'd0;
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // RAM in read-bypass mode for dut1, pipelined for dut2.
  always @(posedge clk) begin
    if (bus1.sbox_cea) bus1.sbox_douta <= sbox_mem[bus1.sbox_ada];
    if (bus1.sbox_ceb) bus1.sbox_doutb <= sbox_mem[bus1.sbox_adb];
    if (bus2.sbox_cea) stage_a <= sbox_mem[bus2.sbox_ada];
    if (bus2.sbox_ceb) stage_b <= sbox_mem[bus2.sbox_adb];
    bus2.sbox_douta <= stage_a;
    bus2.sbox_doutb <= stage_b;
  end

  int k1_n = 0, k1_cyc = -1, s1_n = 0, s1_cyc = -1;
  int k2_n = 0, k2_cyc = -1, s2_n = 0, s2_cyc = -1;
  int ce1_n = 0, low1_n = 0;
  logic [31:0]  k1_res, k2_res;
  logic [127:0] s1_res, s2_res;

  always @(negedge clk) begin
    if (bus1.key_ack) begin k1_n++; k1_cyc = cyc; k1_res = bus1.key_result; end
    if (bus1.st_ack)  begin s1_n++; s1_cyc = cyc; s1_res = bus1.st_result;  end
    if (bus2.key_ack) begin k2_n++; k2_cyc = cyc; k2_res = bus2.key_result; end
    if (bus2.st_ack)  begin s2_n++; s2_cyc = cyc; s2_res = bus2.st_result;  end
    if (bus1.sbox_cea) begin
      ce1_n++;
      if (!bus1.sbox_ada[8]) low1_n++;
    end
    if (bus1.sbox_ceb && !bus1.sbox_adb[8]) low1_n++;
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic key_req, input logic [31:0] key_word,
                               input logic st_req, input logic st_inv, input logic [127:0] st_data);
    if (sel == 1 || sel == 3) begin
      bus1.key_req = key_req; bus1.key_word = key_word;
      bus1.st_req  = st_req;  bus1.st_inv   = st_inv; bus1.st_data = st_data;
    end
    if (sel == 2 || sel == 3) begin
      bus2.key_req = key_req; bus2.key_word = key_word;
      bus2.st_req  = st_req;  bus2.st_inv   = st_inv; bus2.st_data = st_data;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Behaves like a requester: drops its request during its own ack cycle.
  task automatic runReq(input int sel, input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (sel == 1) begin
        if (bus1.key_ack) bus1.key_req = 1'b0;
        if (bus1.st_ack)  bus1.st_req  = 1'b0;
      end else begin
        if (bus2.key_ack) bus2.key_req = 1'b0;
        if (bus2.st_ack)  bus2.st_req  = 1'b0;
      end
    end
  endtask

  task automatic dropReqs();
    bus1.key_req = 1'b0; bus1.st_req = 1'b0;
    bus2.key_req = 1'b0; bus2.st_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t0, kb1, kb2, sb1, sb2, ceb1, lowb1;
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = sbox_f(8'(i));
      sbox_mem[i] = v;
      sbox_mem[256 + int'(v)] = 8'(i);
    end

    reset = 1'b1;
    applyStimulus(3, 1'b0, 32'd0, 1'b0, 1'b0, 128'd0);
    tick(3);
    @(negedge clk);
    checkOutput("reset key_ack", 128'(bus1.key_ack), 128'd0);
    checkOutput("reset busy", 128'(bus1.busy), 128'd0);
    checkOutput("reset cea/ada", 128'({bus1.sbox_cea, bus1.sbox_ada, bus1.sbox_ceb, bus1.sbox_adb}), 128'd0);
    checkOutput("reset st_result", bus2.st_result, 128'd0);
    tick(1);
    reset = 1'b0;
    tick(1);

    // Key op on both latencies, with address check on dut1.
    t0 = cyc; kb1 = k1_n; kb2 = k2_n;
    applyStimulus(3, 1'b1, 32'h04030201, 1'b0, 1'b0, 128'd0);
    tick(1);
    dropReqs();
    @(negedge clk);
    checkOutput("key addr T+1", 128'({bus1.sbox_cea, bus1.sbox_ada, bus1.sbox_ceb, bus1.sbox_adb}),
                128'({1'b1, 9'h001, 1'b1, 9'h002}));
    tick(1);
    @(negedge clk);
    checkOutput("key addr T+2", 128'({bus1.sbox_ada, bus1.sbox_adb}), 128'({9'h003, 9'h004}));
    tick(6);
    checkOutput("key1 ack count", 128'(k1_n - kb1), 128'd1);
    checkOutput("key1 ack cycle", 128'(k1_cyc - t0), 128'd4);
    checkOutput("key1 result", 128'(k1_res), 128'h F27B777C);
    checkOutput("key2 ack cycle", 128'(k2_cyc - t0), 128'd5);
    checkOutput("key2 result", 128'(k2_res), 128'hF27B777C);

    // Forward state op.
    t0 = cyc; sb1 = s1_n; sb2 = s2_n;
    applyStimulus(3, 1'b0, 32'h04030201, 1'b1, 1'b0, 128'h53);
    tick(1);
    dropReqs();
    tick(13);
    checkOutput("st1 ack count", 128'(s1_n - sb1), 128'd1);
    checkOutput("st1 fwd ack cycle", 128'(s1_cyc - t0), 128'd10);
    checkOutput("st1 fwd result", s1_res, {{15{8'h63}}, 8'hED});
    checkOutput("st2 fwd ack cycle", 128'(s2_cyc - t0), 128'd11);
    checkOutput("st2 fwd result", s2_res, {{15{8'h63}}, 8'hED});
    checkOutput("key1 result kept", 128'(bus1.key_result), 128'hF27B777C);

    // Inverse state ops.
    ceb1 = ce1_n; lowb1 = low1_n;
    applyStimulus(3, 1'b0, 32'd0, 1'b1, 1'b1, 128'd0);
    tick(1);
    dropReqs();
    tick(13);
    checkOutput("st1 inv00 result", s1_res, {16{8'h52}});
    checkOutput("st2 inv00 result", s2_res, {16{8'h52}});
    checkOutput("inv issue cycles", 128'(ce1_n - ceb1), 128'd8);
    checkOutput("inv addr bit8 low", 128'(low1_n - lowb1), 128'd0);
    applyStimulus(3, 1'b0, 32'd0, 1'b1, 1'b1, {16{8'h63}});
    tick(1);
    dropReqs();
    tick(13);
    checkOutput("st1 inv63 result", s1_res, 128'd0);
    checkOutput("st2 inv63 result", s2_res, 128'd0);

    // Ties on dut1 after reset: key, key again, then state after a lone key op.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    t0 = cyc;
    applyStimulus(1, 1'b1, 32'h00000053, 1'b1, 1'b0, 128'd0);
    runReq(1, 20);
    checkOutput("tie1 key ack cycle", 128'(k1_cyc - t0), 128'd4);
    checkOutput("tie1 st ack cycle", 128'(s1_cyc - t0), 128'd15);
    checkOutput("tie1 key result", 128'(k1_res), 128'h636363ED);
    checkOutput("tie1 st result", s1_res, {16{8'h63}});
    t0 = cyc;
    applyStimulus(1, 1'b1, 32'h01010101, 1'b1, 1'b1, 128'd0);
    runReq(1, 20);
    checkOutput("tie2 key ack cycle", 128'(k1_cyc - t0), 128'd4);
    checkOutput("tie2 st ack cycle", 128'(s1_cyc - t0), 128'd15);
    checkOutput("tie2 key result", 128'(k1_res), 128'h7C7C7C7C);
    checkOutput("tie2 st result", s1_res, {16{8'h52}});
`ifdef SBOX_LOOKUP_ARBITER_STATS_EN
    checkOutput("stat conflicts", 128'(s1_conf), 128'd2);
    checkOutput("stat key ops", 128'(s1_key), 128'd2);
    checkOutput("stat st ops", 128'(s1_st), 128'd2);
`endif
    applyStimulus(1, 1'b1, 32'h00000000, 1'b0, 1'b0, 128'd0);
    runReq(1, 6);
    t0 = cyc;
    applyStimulus(1, 1'b1, 32'h02020202, 1'b1, 1'b0, {16{8'h53}});
    runReq(1, 20);
    checkOutput("tie3 st ack cycle", 128'(s1_cyc - t0), 128'd10);
    checkOutput("tie3 key ack cycle", 128'(k1_cyc - t0), 128'd15);
    checkOutput("tie3 key result", 128'(k1_res), 128'h77777777);
    checkOutput("tie3 st result", s1_res, {16{8'hED}});

    // Reset in the middle of ISSUE for a state op.
    sb1 = s1_n; sb2 = s2_n;
    applyStimulus(3, 1'b0, 32'd0, 1'b1, 1'b1, 128'd0);
    tick(1);
    dropReqs();
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst busy", 128'({bus1.busy, bus2.busy}), 128'd0);
    checkOutput("midrst key_result", 128'(bus1.key_result), 128'd0);
    checkOutput("midrst st_result", bus1.st_result, 128'd0);
    checkOutput("midrst key_result2", 128'(bus2.key_result), 128'd0);
    checkOutput("midrst cea", 128'({bus1.sbox_cea, bus2.sbox_cea, bus1.st_ack, bus2.st_ack}), 128'd0);
    tick(15);
    checkOutput("midrst no st_ack", 128'((s1_n - sb1) + (s2_n - sb2)), 128'd0);
    t0 = cyc;
    applyStimulus(3, 1'b1, 32'h04030201, 1'b0, 1'b0, 128'd0);
    tick(1);
    dropReqs();
    tick(8);
    checkOutput("post-rst key1 cycle", 128'(k1_cyc - t0), 128'd4);
    checkOutput("post-rst key1 result", 128'(k1_res), 128'hF27B777C);
    checkOutput("post-rst key2 result", 128'(k2_res), 128'hF27B777C);

    // READ_LAT=2: key op followed back-to-back by a state op.
    t0 = cyc;
    applyStimulus(2, 1'b1, 32'h00000000, 1'b0, 1'b0, 128'd0);
    tick(1);
    applyStimulus(2, 1'b0, 32'h00000000, 1'b1, 1'b0, 128'h0f0e0d0c0b0a09080706050403020100);
    runReq(2, 20);
    checkOutput("lat2 key ack cycle", 128'(k2_cyc - t0), 128'd5);
    checkOutput("lat2 key result", 128'(k2_res), 128'h63636363);
    checkOutput("lat2 b2b st latency", 128'(s2_cyc - (k2_cyc + 1)), 128'd11);
    checkOutput("lat2 b2b st result", s2_res, 128'h76abd7fe2b670130c56f6bf27b777c63);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sbox_lookup_arbiter.md
Name: sbox_lookup_arbiter

Overview:
Shares one dual-port S-box block RAM between two requesters: the key-expansion SubWord path (4 bytes, forward S-box only) and the round datapath SubBytes/InvSubBytes path (16 bytes, forward or inverse). The RAM holds the forward S-box at addresses 0x000-0x0FF and the inverse S-box at 0x100-0x1FF. Each granted operation is issued at two lookups per cycle, one on each RAM port. Read results are collected into a result register, and the requester gets a single-cycle ack.

Parameters:
READ_LAT, 1, RAM read latency in cycles. Legal values are 1 (RAM read mode bypass) or 2 (RAM read mode pipeline). Must match the RAM instance.

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
key_req  in  1  key-expansion request; key_word held stable until key_ack
key_word  in  32  SubWord operand; byte i = key_word[8i+7:8i]
key_ack  out  1  one-cycle pulse; key_result valid in the same cycle
key_result  out  32  substituted word; held until the next key op completes
st_req  in  1  round-datapath request; st_data/st_inv held until st_ack
st_inv  in  1  0 = forward S-box, 1 = inverse S-box
st_data  in  128  state operand; byte i = st_data[8i+7:8i]
st_ack  out  1  one-cycle pulse; st_result valid in the same cycle
st_result  out  128  substituted state; held until the next state op completes
busy  out  1  high whenever the FSM is not in IDLE
sbox_cea  out  1  port A clock enable
sbox_ada  out  9  port A address
sbox_ceb  out  1  port B clock enable
sbox_adb  out  9  port B address
sbox_douta  in  8  port A read data
sbox_doutb  in  8  port B read data

Behaviour:
- Reset values: every output is 0, FSM is in IDLE, the in-flight tag pipeline is cleared, last_grant = STATE.
- RAM write enables are tied low and output-clock-enables tied high at instantiation. The RAM is never written.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - Samples the requests.
  - If only one request is high, that requester is granted.
  - If both are high, the requester other than last_grant is granted (round-robin). After reset the key path wins the first tie.
  - On grant: latch the operand, N (4 or 16) and inv (forced 0 for key). Update last_grant. Go to ISSUE.
- ISSUE:
  - Runs for N/2 cycles, k = 0 .. N/2-1.
  - Port A gets {inv, byte 2k}; port B gets {inv, byte 2k+1}. cea and ceb are both 1.
  - Pushes tag k into a READ_LAT-deep valid/index shift register.
  - After the last pair, go to DRAIN.
- Outside ISSUE: cea = ceb = 0 and both addresses = 0.
- Capture: when a tag emerges from the shift register, douta is written to result byte 2k and doutb to result byte 2k+1. Only the granted requester's result register is written.
- DRAIN:
  - Lasts READ_LAT cycles, until the last tag has been captured.
  - Then go to DONE.
- DONE: lasts one cycle. The granted requester's ack = 1. Next state is IDLE.
- Latency: if the accept cycle is T, ack occurs at T+1+N/2+READ_LAT.
  - Key op: T+4 with READ_LAT = 1, T+5 with READ_LAT = 2.
  - State op: T+10 with READ_LAT = 1, T+11 with READ_LAT = 2.
- Throughput: one op per (N/2 + READ_LAT + 2) cycles. Requests are sampled in IDLE only.
- Dropping a request after it has been accepted does not abort the operation; ack still pulses.
- A request still high in the cycle after ack is treated as a new request. Requesters deassert in the ack cycle.
- An idle requester's result register and ack are unaffected by the other requester's operations.
- Reset mid-operation:
  - Return to IDLE, clear the tags, zero the results and acks.
  - RAM data still in flight is discarded.
  - last_grant returns to STATE.

Optional Feature:
Macro SBOX_LOOKUP_ARBITER_STATS_EN.
- When defined, adds three outputs:
  - stat_key_ops[15:0]: completed key ops.
  - stat_st_ops[15:0]: completed state ops.
  - stat_conflicts[15:0]: IDLE cycles with both requests high.
- All three counters saturate at 0xFFFF and clear on reset.
- When the macro is undefined, these ports and the counter logic are absent. Core behaviour is identical either way.

Test Plan:
- Key word, READ_LAT = 1:
  - key_word = 0x04030201 accepted at T → key_ack at T+4, key_result = 0xF27B777C.
  - Port addresses are 0x001/0x002 at T+1 and 0x003/0x004 at T+2.
- State, forward, READ_LAT = 1:
  - st_inv = 0, st_data = 0x...0053 (byte0 = 0x53, all other bytes 0x00) → st_ack at T+10.
  - st_result byte0 = 0xED, all other bytes = 0x63.
- State, inverse:
  - st_inv = 1, st_data all 0x00 → st_result all 0x52. Every issued address has bit 8 = 1.
  - Repeat with all 0x63 → st_result all 0x00.
- Simultaneous requests after reset:
  - key_req and st_req both rise in one cycle → key granted first (ack at T+4), then state accepted in the IDLE cycle after DONE.
  - A second tie then grants key again, because last_grant = STATE.
  - With the stats macro defined, stat_conflicts = 2.
- Reset mid-ISSUE during a state op:
  - reset for 1 cycle → all outputs 0, no st_ack.
  - A fresh key op then completes with the correct result, unaffected by stale RAM data.
- READ_LAT = 2 build:
  - key_word = 0x00000000 → key_ack at T+5, key_result = 0x63636363.
  - Back-to-back state op → st_ack 11 cycles after its accept.
